sap1_controller_sequencer: RTL and testbench

- Control/sequencer unit for the SAP-1 datapath.
- Steps a one-hot ring counter through T-states T1..T6.
- Decodes the instruction register opcode nibble.
- Drives the control word that sequences the program counter, MAR, RAM, IR, accumulator, ALU, B and output registers over the shared w_bus.
- Owns the fetch cycle that loads the MAR from the PC, and the execute cycles that reload the MAR from the IR operand.

---
 rtl/sap1_controller_sequencer_if.sv | 9 +
 rtl/sap1_controller_sequencer.sv | 69 ++++++
 tb/tb_sap1_controller_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sap1_controller_sequencer_if.sv
// sap1_controller_sequencer_if: opcode in, control word and T-state out between sequencer and datapath.
interface sap1_controller_sequencer_if;
    logic [3:0]  opcode;
    logic [11:0] control_word;
    logic [5:0]  t_state;
    logic        hlt;
    modport master (input opcode, output control_word, t_state, hlt);
    modport slave (output opcode, input control_word, t_state, hlt);
endinterface

// File: rtl/sap1_controller_sequencer.sv
// sap1_controller_sequencer: SAP-1 T1..T6 ring counter, opcode decode and control word.
// Define SAP1_CTRL_EARLY_FETCH_EN to end LDA/OUT/NOP early instead of always running six states.
module sap1_controller_sequencer #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input logic clk,
    input logic clr,
    sap1_controller_sequencer_if.master bus
);
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    t_state_e    state;
    t_state_e    next;
    logic        halted;
    logic        done;
    logic [11:0] exec;

`ifdef SAP1_CTRL_EARLY_FETCH_EN
    logic nop;
    assign nop = bus.opcode != OP_LDA && bus.opcode != OP_ADD && bus.opcode != OP_SUB &&
                 bus.opcode != OP_OUT && bus.opcode != OP_HLT;
    assign done = (state == T5 && bus.opcode == OP_LDA) || (state == T4 && bus.opcode == OP_OUT) ||
                  (state == T3 && nop);
`else
    assign done = 1'b0;
`endif

    // Illegal (non-one-hot) states fall back to T1.
    assign next = (!$onehot(state) || done) ? T1 : t_state_e'({state[4:0], state[5]});

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= T1;
            halted <= 1'b0;
        end else if (!halted) begin
            if (state == T4 && bus.opcode == OP_HLT) halted <= 1'b1;
            else state <= next;
        end
    end

    always_comb begin
        exec = 12'h000;
        case (bus.opcode)
            OP_LDA:  exec = state == T4 ? 12'h240 : state == T5 ? 12'h120 : 12'h000;
            OP_ADD:  exec = state == T4 ? 12'h240 : state == T5 ? 12'h102 : state == T6 ? 12'h024 : 12'h000;
            OP_SUB:  exec = state == T4 ? 12'h240 : state == T5 ? 12'h102 : state == T6 ? 12'h02C : 12'h000;
            OP_OUT:  exec = state == T4 ? 12'h011 : 12'h000;
            default: exec = 12'h000;
        endcase
    end

    assign bus.control_word = (clr || halted) ? 12'h000 :
                              state == T1 ? 12'h600 :
                              state == T2 ? 12'h800 :
                              state == T3 ? 12'h180 : exec;
    assign bus.t_state = state;
    assign bus.hlt     = halted;
endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// tb_sap1_controller_sequencer: directed checks of fetch/execute words, halt and reset abort.
module tb_sap1_controller_sequencer;
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic clk;
    logic clr;
    int   errors;
    int   checks;

    sap1_controller_sequencer_if bus ();

    sap1_controller_sequencer dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rst_seq();
        clr = 1'b1;
        step();
        clr = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus.opcode = OP_ADD;
        clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.control_word !== 12'h000) begin
                errors++;
                $display("FAIL reset_cw[%0d] got=%h exp=000", i, bus.control_word);
            end
            checks++;
            if (bus.t_state !== 6'b000001) begin
                errors++;
                $display("FAIL reset_t[%0d] got=%b exp=000001", i, bus.t_state);
            end
        end
        clr = 1'b0;
        #1;
        checks++;
        if (bus.hlt !== 1'b0) begin
            errors++;
            $display("FAIL reset_hlt got=%b exp=0", bus.hlt);
        end
        checks++;
        if (bus.control_word !== 12'h600) begin
            errors++;
            $display("FAIL reset_t1 got=%h exp=600", bus.control_word);
        end
        step();
        checks++;
        if (bus.control_word !== 12'h800) begin
            errors++;
            $display("FAIL reset_t2 got=%h exp=800", bus.control_word);
        end
        step();
        checks++;
        if (bus.control_word !== 12'h180) begin
            errors++;
            $display("FAIL reset_t3 got=%h exp=180", bus.control_word);
        end
    endtask

    task automatic run_seq(input string name, input logic [3:0] op,
                           input logic [11:0] ew [7], input logic [5:0] et [7]);
        bus.opcode = op;
        rst_seq();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            checks++;
            if (bus.control_word !== ew[i] || bus.t_state !== et[i]) begin
                errors++;
                $display("FAIL %s[%0d] got cw=%h t=%b exp cw=%h t=%b",
                         name, i, bus.control_word, bus.t_state, ew[i], et[i]);
            end
        end
    endtask

    task automatic test_lda();
`ifdef SAP1_CTRL_EARLY_FETCH_EN
        run_seq("lda", OP_LDA, '{12'h600, 12'h800, 12'h180, 12'h240, 12'h120, 12'h600, 12'h800},
                '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd1, 6'd2});
`else
        run_seq("lda", OP_LDA, '{12'h600, 12'h800, 12'h180, 12'h240, 12'h120, 12'h000, 12'h600},
                '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd1});
`endif
    endtask

    task automatic test_out();
`ifdef SAP1_CTRL_EARLY_FETCH_EN
        run_seq("out", OP_OUT, '{12'h600, 12'h800, 12'h180, 12'h011, 12'h600, 12'h800, 12'h180},
                '{6'd1, 6'd2, 6'd4, 6'd8, 6'd1, 6'd2, 6'd4});
`else
        run_seq("out", OP_OUT, '{12'h600, 12'h800, 12'h180, 12'h011, 12'h000, 12'h000, 12'h600},
                '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd1});
`endif
    endtask

    task automatic test_nop();
`ifdef SAP1_CTRL_EARLY_FETCH_EN
        run_seq("nop", 4'h7, '{12'h600, 12'h800, 12'h180, 12'h600, 12'h800, 12'h180, 12'h600},
                '{6'd1, 6'd2, 6'd4, 6'd1, 6'd2, 6'd4, 6'd1});
`else
        run_seq("nop", 4'h7, '{12'h600, 12'h800, 12'h180, 12'h000, 12'h000, 12'h000, 12'h600},
                '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd1});
`endif
    endtask

    task automatic test_back_to_back();
        logic [11:0] ew [12];
        ew = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h024,
               12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h02C};
        bus.opcode = OP_ADD;
        rst_seq();
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step();
            if (i == 6) begin
                bus.opcode = OP_SUB;
                #1;
            end
            checks++;
            if (bus.control_word !== ew[i]) begin
                errors++;
                $display("FAIL b2b_cw[%0d] got=%h exp=%h", i, bus.control_word, ew[i]);
            end
            checks++;
            if ($countones(bus.control_word & 12'h554) > 1) begin
                errors++;
                $display("FAIL b2b_bus[%0d] got=%h exp at most one of Ep/CE/Ei/Ea/Eu", i, bus.control_word);
            end
        end
    endtask

    task automatic test_hlt();
        logic [11:0] ew [4];
        ew = '{12'h600, 12'h800, 12'h180, 12'h000};
        bus.opcode = OP_HLT;
        rst_seq();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            checks++;
            if (bus.control_word !== ew[i] || bus.hlt !== 1'b0) begin
                errors++;
                $display("FAIL hlt_pre[%0d] got cw=%h hlt=%b exp cw=%h hlt=0", i, bus.control_word, bus.hlt, ew[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (bus.hlt !== 1'b1 || bus.t_state !== 6'b001000 || bus.control_word !== 12'h000) begin
                errors++;
                $display("FAIL hlt_hold[%0d] got hlt=%b t=%b cw=%h exp hlt=1 t=001000 cw=000",
                         i, bus.hlt, bus.t_state, bus.control_word);
            end
        end
        rst_seq();
        checks++;
        if (bus.hlt !== 1'b0 || bus.t_state !== 6'b000001 || bus.control_word !== 12'h600) begin
            errors++;
            $display("FAIL hlt_clr got hlt=%b t=%b cw=%h exp hlt=0 t=000001 cw=600",
                     bus.hlt, bus.t_state, bus.control_word);
        end
    endtask

    task automatic test_abort();
        bus.opcode = OP_ADD;
        rst_seq();
        repeat (4) step();
        checks++;
        if (bus.t_state !== 6'b010000) begin
            errors++;
            $display("FAIL abort_t5 got=%b exp=010000", bus.t_state);
        end
        clr = 1'b1;
        #1;
        checks++;
        if ((bus.control_word & 12'h022) !== 12'h000) begin
            errors++;
            $display("FAIL abort_lb got=%h exp La/Lb low", bus.control_word);
        end
        step();
        clr = 1'b0;
        #1;
        checks++;
        if (bus.t_state !== 6'b000001 || bus.control_word !== 12'h600) begin
            errors++;
            $display("FAIL abort_t1 got t=%b cw=%h exp t=000001 cw=600", bus.t_state, bus.control_word);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clr = 1'b1;
        bus.opcode = OP_LDA;
        @(negedge clk);
        test_reset();
        test_lda();
        test_back_to_back();
        test_out();
        test_nop();
        test_hlt();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
